circuit_sweep: RTL and testbench
================================

# circuit_sweep

Exhaustive stimulus driver and response collector for the 5-bit combinational `circuit` block. On a start pulse it drives every input vector 0..2^WIDTH-1 onto the circuit input in ascending order. For each vector it samples the circuit response and streams the {vector, response} pair out over a valid/ready interface. It also compacts all responses into a signature, so a truth table can be checked in a single compare. It sits directly upstream of `circuit` (drives `in`) and consumes its `out` on the same cycle.

## Interface
Parameters:
- `WIDTH`, 5, stimulus/response width; the sweep covers 2^WIDTH vectors.
- `POLY`, 5'h05, Galois MISR feedback taps (x^5+x^2+1).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a sweep; sampled only in IDLE.
- `stim_o`  out  WIDTH  registered vector driven to `circuit.in`.
- `resp_i`  in  WIDTH  combinational response from `circuit.out`.
- `busy`  out  1  high from the cycle after start is accepted until the last record drains.
- `done`  out  1  one-cycle pulse when the sweep is complete.
- `signature`  out  WIDTH  compacted response; final while `done` is high and held until the next start.
- `rec_valid`  out  1  record register holds an unconsumed pair.
- `rec_ready`  in  1  downstream accepts the record.
- `rec_data`  out  2*WIDTH  {vector, response}; vector in the upper bits.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE, start=1:
  - Go to RUN.
  - `stim_o` <= 0, `signature` <= 0, `busy` <= 1.
- RUN:
  - Capture edge occurs when `!rec_valid || rec_ready`.
  - On a capture edge:
    - `rec_data` <= {stim_o, resp_i}; `rec_valid` <= 1.
    - Fold `resp_i` into `signature`.
    - If `stim_o` is all ones, go to DRAIN and hold `stim_o`; otherwise `stim_o` <= `stim_o` + 1.
  - No capture edge: `stim_o`, `signature` and the record register hold.
- DRAIN:
  - When `rec_valid && rec_ready` (or `!rec_valid`): `rec_valid` <= 0, `busy` <= 0, `done` <= 1, `stim_o` <= 0, go to IDLE.
- `done` is cleared the following cycle.
- `rec_valid`/`rec_data` must not change while `rec_valid && !rec_ready`.
- `start` is ignored outside IDLE. `start` in the cycle `done` is high is accepted: `done` clears and a new sweep begins.
- Reset values: `stim_o`=0, `busy`=0, `done`=0, `signature`=0, `rec_valid`=0, `rec_data`=0; state=IDLE.
- `rst` mid-sweep aborts at the next edge. The partial record is discarded and no `done` is produced.
- `rst` with `start` in the same cycle: reset wins.
- Counter arithmetic is WIDTH-bit unsigned. The all-ones check, not wrap-around, terminates the sweep.

## Timing
- `start` sampled at edge E0 → `busy`=1 and `stim_o`=0 after E0.
- `rec_ready` held high:
  - Vector n is captured at edge E(n+1).
  - `rec_valid` is high after E1 through E32.
  - DRAIN is entered after E32.
  - `done`=1 after E33, i.e. 33 cycles after start for WIDTH=5.
- Each cycle with `rec_valid && !rec_ready` adds exactly one cycle to the total.
- Throughput: one vector per cycle when not stalled.
- `resp_i` is sampled in the same cycle `stim_o` is presented. This is a single combinational path through `circuit`, which must close in one cycle.

## Configuration
- Macro `CIRCUIT_SWEEP_MISR_EN`.
- Defined: `signature` <= {signature[WIDTH-2:0],1'b0} ^ (signature[WIDTH-1] ? POLY : 0) ^ resp_i. The result is order-sensitive.
- Undefined: `signature` <= signature ^ resp_i, a per-bit parity that is order-insensitive. `POLY` is unused.
- Record stream and timing are identical in both builds.

## Test plan
- Connected to `circuit`, `rec_ready`=1, start pulse:
  - 32 records, vectors 0..31 in order.
  - First record `rec_data`=10'h00F ({0, 5'h0F}); last record {5'h1F, 5'h18}.
  - `done` exactly 33 cycles after start.
  - `signature` equals the bit-accurate model.
- Loopback (`resp_i`=`stim_o`), MISR undefined: final `signature`=5'h00. Response tied to 5'h00, either build: `signature`=5'h00.
- Backpressure: `rec_ready` low for 3 cycles at vector 7:
  - `rec_data` stable at {7, resp(7)} throughout.
  - `stim_o` holds at 8.
  - `done` at cycle 36.
  - No record lost or duplicated.
- Assert `rst` at vector 12: next cycle all outputs are at reset values and no `done` occurs. A subsequent start sweeps from 0.
- `start` pulses during RUN are ignored with no restart. `start` coincident with `done` begins a new sweep and `busy` is high the next cycle.
- `rec_ready` low for the whole sweep: stall at vector 0 with `busy`=1 and `stim_o`=1. Releasing `rec_ready` completes the sweep normally.

Source files
------------

// File: rtl/circuit_sweep.sv
// circuit_sweep: exhaustive stimulus driver and response collector for the
// WIDTH-bit combinational `circuit` block. Drives vectors 0..2^WIDTH-1 in order,
// streams {vector, response} records over valid/ready and compacts the
// responses into a signature.
// Optional feature: define CIRCUIT_SWEEP_MISR_EN to fold responses through a
// Galois MISR (taps = POLY); otherwise the signature is plain per-bit parity.
`timescale 1ns/1ps
module circuit_sweep #(
    parameter int unsigned      WIDTH = 5,
    parameter logic [WIDTH-1:0] POLY  = 5'h05
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [WIDTH-1:0]   stim_o,
    input  logic [WIDTH-1:0]   resp_i,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   signature,
    output logic               rec_valid,
    input  logic               rec_ready,
    output logic [2*WIDTH-1:0] rec_data
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   stim_q, stim_d;
    logic [WIDTH-1:0]   sig_q, sig_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               rec_valid_q, rec_valid_d;
    logic [2*WIDTH-1:0] rec_data_q, rec_data_d;

    // The record register may be (re)loaded when empty or being consumed.
    logic capture;

    // Fold one response into the running signature.
    function automatic logic [WIDTH-1:0] fold_sig(input logic [WIDTH-1:0] sig,
                                                  input logic [WIDTH-1:0] resp);
`ifdef CIRCUIT_SWEEP_MISR_EN
        fold_sig = {sig[WIDTH-2:0], 1'b0} ^ (sig[WIDTH-1] ? POLY : '0) ^ resp;
`else
        fold_sig = sig ^ resp;
`endif
    endfunction

`ifndef CIRCUIT_SWEEP_MISR_EN
    // Parity build has no feedback taps; keep the parameter visibly consumed.
    logic [WIDTH-1:0] unused_poly;
    assign unused_poly = POLY;
`endif

    assign capture = !rec_valid_q || rec_ready;

    // Next-state and datapath update for the sweep sequencer.
    always_comb begin
        state_d     = state_q;
        stim_d      = stim_q;
        sig_d       = sig_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        rec_valid_d = rec_valid_q;
        rec_data_d  = rec_data_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    stim_d  = '0;
                    sig_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_RUN: begin
                if (capture) begin
                    rec_data_d  = {stim_q, resp_i};
                    rec_valid_d = 1'b1;
                    sig_d       = fold_sig(sig_q, resp_i);
                    // Terminate on the last vector rather than relying on wrap.
                    if (&stim_q) begin
                        state_d = ST_DRAIN;
                    end else begin
                        stim_d = stim_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (capture) begin
                    rec_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    stim_d      = '0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset clears control and record outputs alike.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            stim_q      <= '0;
            sig_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rec_valid_q <= 1'b0;
            rec_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            stim_q      <= stim_d;
            sig_q       <= sig_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rec_valid_q <= rec_valid_d;
            rec_data_q  <= rec_data_d;
        end
    end

    assign stim_o    = stim_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign signature = sig_q;
    assign rec_valid = rec_valid_q;
    assign rec_data  = rec_data_q;

endmodule

// File: tb/tb_circuit_sweep.sv
// Directed testbench for circuit_sweep. A stand-in `circuit` (23*x+15 mod 32)
// plus loopback, all-zero and sparse response sources drive resp_i.
`timescale 1ns/1ps
module tb_circuit_sweep;
    localparam int W = 5;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           rec_ready = 1'b1;
    logic [W-1:0]   stim_o, resp_i, signature;
    logic           busy, done, rec_valid;
    logic [2*W-1:0] rec_data;
    int             mode = 0;
    int             n_checks = 0;
    int             n_fail = 0;
    logic [2*W-1:0] recs[$];

    circuit_sweep #(.WIDTH(W), .POLY(5'h05)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stim_o    (stim_o),
        .resp_i    (resp_i),
        .busy      (busy),
        .done      (done),
        .signature (signature),
        .rec_valid (rec_valid),
        .rec_ready (rec_ready),
        .rec_data  (rec_data)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] circ(input logic [W-1:0] x);
        logic [W-1:0] t;
        t = x * 5'd23;
        return t + 5'd15;
    endfunction

    function automatic logic [W-1:0] resp_of(input int m, input logic [W-1:0] x);
        case (m)
            0:       return circ(x);
            1:       return x;
            2:       return 5'h00;
            default: return (x == 5'd5) ? 5'h0A : 5'h00;
        endcase
    endfunction

    function automatic logic [W-1:0] sig_model(input int m);
        logic [W-1:0] s;
        logic [W-1:0] r;
        s = 5'h00;
        for (int i = 0; i < 32; i++) begin
            r = resp_of(m, 5'(i));
`ifdef CIRCUIT_SWEEP_MISR_EN
            s = {s[3:0], 1'b0} ^ (s[4] ? 5'h05 : 5'h00) ^ r;
`else
            s = s ^ r;
`endif
        end
        return s;
    endfunction

    always_comb resp_i = resp_of(mode, stim_o);

    always @(posedge clk) begin
        if (!rst && rec_valid && rec_ready) recs.push_back(rec_data);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(inout int k);
        int guard;
        guard = 0;
        while (done !== 1'b1 && guard < 300) begin
            tick();
            k++;
            guard++;
        end
        if (done !== 1'b1) begin
            n_checks++; n_fail++;
            $display("FAIL done_timeout: done=%b after %0d cycles, required 1", done, guard);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; rec_ready = 1'b1; mode = 0;
        tick(); tick();
        rst = 1'b0;
        n_checks++; if (stim_o !== 5'h00) begin n_fail++; $display("FAIL reset_stim: got %h, required 00", stim_o); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b, required 0", done); end
        n_checks++; if (signature !== 5'h00) begin n_fail++; $display("FAIL reset_sig: got %h, required 00", signature); end
        n_checks++; if (rec_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, required 0", rec_valid); end
        n_checks++; if (rec_data !== 10'h000) begin n_fail++; $display("FAIL reset_data: got %h, required 000", rec_data); end
    endtask

    task automatic test_sweep();
        int k;
        int bad;
        logic [W-1:0] v;
        mode = 0; rec_ready = 1'b1; recs.delete();
        do_start();
        k = 0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL sweep_busy_start: got %b, required 1", busy); end
        n_checks++; if (stim_o !== 5'h00) begin n_fail++; $display("FAIL sweep_stim_start: got %h, required 00", stim_o); end
        wait_done(k);
        n_checks++; if (k !== 33) begin n_fail++; $display("FAIL sweep_latency: got %0d, required 33", k); end
        n_checks++; if (signature !== sig_model(0)) begin n_fail++; $display("FAIL sweep_sig: got %h, required %h", signature, sig_model(0)); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sweep_busy_end: got %b, required 0", busy); end
        n_checks++; if (recs.size() !== 32) begin n_fail++; $display("FAIL sweep_count: got %0d, required 32", recs.size()); end
        if (recs.size() == 32) begin
            n_checks++; if (recs[0] !== 10'h00F) begin n_fail++; $display("FAIL sweep_first: got %h, required 00f", recs[0]); end
            n_checks++; if (recs[31] !== {5'h1F, 5'h18}) begin n_fail++; $display("FAIL sweep_last: got %h, required 3f8", recs[31]); end
            bad = 0;
            for (int i = 0; i < 32; i++) begin
                v = 5'(i);
                if (recs[i] !== {v, circ(v)}) bad++;
            end
            n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL sweep_order: got %0d bad records, required 0", bad); end
        end
        tick();
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL sweep_done_pulse: got %b, required 0", done); end
        n_checks++; if (signature !== sig_model(0)) begin n_fail++; $display("FAIL sweep_sig_hold: got %h, required %h", signature, sig_model(0)); end
    endtask

    task automatic test_signatures();
        int k;
        logic [W-1:0] exp_loop;
        logic [W-1:0] exp_sparse;
`ifdef CIRCUIT_SWEEP_MISR_EN
        exp_loop   = sig_model(1);
        exp_sparse = sig_model(3);
`else
        exp_loop   = 5'h00;
        exp_sparse = 5'h0A;
`endif
        rec_ready = 1'b1;
        mode = 1; do_start(); k = 0; wait_done(k);
        n_checks++; if (signature !== exp_loop) begin n_fail++; $display("FAIL sig_loopback: got %h, required %h", signature, exp_loop); end
        mode = 2; do_start(); k = 0; wait_done(k);
        n_checks++; if (signature !== 5'h00) begin n_fail++; $display("FAIL sig_zero: got %h, required 00", signature); end
        mode = 3; do_start(); k = 0; wait_done(k);
        n_checks++; if (signature !== exp_sparse) begin n_fail++; $display("FAIL sig_sparse: got %h, required %h", signature, exp_sparse); end
        mode = 0;
    endtask

    task automatic test_backpressure();
        int k;
        int bad;
        logic [W-1:0] v;
        mode = 0; rec_ready = 1'b1; recs.delete();
        do_start();
        k = 0;
        while (done !== 1'b1 && k < 300) begin
            if (k >= 8 && k <= 11) begin
                n_checks++; if (rec_data !== 10'h0F0) begin n_fail++; $display("FAIL bp_data_k%0d: got %h, required 0f0", k, rec_data); end
                n_checks++; if (stim_o !== 5'd8) begin n_fail++; $display("FAIL bp_stim_k%0d: got %h, required 08", k, stim_o); end
            end
            rec_ready = (k >= 8 && k <= 10) ? 1'b0 : 1'b1;
            tick();
            k++;
        end
        rec_ready = 1'b1;
        n_checks++; if (k !== 36) begin n_fail++; $display("FAIL bp_latency: got %0d, required 36", k); end
        n_checks++; if (recs.size() !== 32) begin n_fail++; $display("FAIL bp_count: got %0d, required 32", recs.size()); end
        if (recs.size() == 32) begin
            bad = 0;
            for (int i = 0; i < 32; i++) begin
                v = 5'(i);
                if (recs[i] !== {v, circ(v)}) bad++;
            end
            n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL bp_order: got %0d bad records, required 0", bad); end
        end
    endtask

    task automatic test_reset_mid();
        int k;
        logic seen_done;
        mode = 0; rec_ready = 1'b1;
        do_start();
        k = 0;
        while (stim_o !== 5'd12 && k < 100) begin tick(); k++; end
        n_checks++; if (k !== 12) begin n_fail++; $display("FAIL rst_mid_reach: got %0d, required 12", k); end
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        n_checks++; if (stim_o !== 5'h00) begin n_fail++; $display("FAIL rst_mid_stim: got %h, required 00", stim_o); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b, required 0", busy); end
        n_checks++; if (signature !== 5'h00) begin n_fail++; $display("FAIL rst_mid_sig: got %h, required 00", signature); end
        n_checks++; if (rec_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b, required 0", rec_valid); end
        n_checks++; if (rec_data !== 10'h000) begin n_fail++; $display("FAIL rst_mid_data: got %h, required 000", rec_data); end
        seen_done = 1'b0;
        repeat (40) begin
            tick();
            if (done === 1'b1) seen_done = 1'b1;
        end
        n_checks++; if (seen_done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_no_done: got %b, required 0", seen_done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_idle: got %b, required 0", busy); end
        do_start();
        k = 0;
        tick(); k++;
        n_checks++; if (rec_data !== 10'h00F) begin n_fail++; $display("FAIL rst_mid_restart: got %h, required 00f", rec_data); end
        wait_done(k);
        n_checks++; if (k !== 33) begin n_fail++; $display("FAIL rst_mid_latency: got %0d, required 33", k); end
    endtask

    task automatic test_back_to_back();
        int k;
        int bad;
        logic [W-1:0] v;
        mode = 0; rec_ready = 1'b1; recs.delete();
        do_start();
        k = 0;
        while (done !== 1'b1 && k < 300) begin
            start = (k == 5 || k == 10 || k == 20) ? 1'b1 : 1'b0;
            tick();
            k++;
        end
        start = 1'b0;
        n_checks++; if (k !== 33) begin n_fail++; $display("FAIL run_start_latency: got %0d, required 33", k); end
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            v = 5'(i);
            if (i >= recs.size() || recs[i] !== {v, circ(v)}) bad++;
        end
        n_checks++; if (bad !== 0 || recs.size() !== 32) begin n_fail++; $display("FAIL run_start_records: got %0d bad of %0d, required 0 of 32", bad, recs.size()); end
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got %b, required 1", busy); end
        n_checks++; if (stim_o !== 5'h00) begin n_fail++; $display("FAIL b2b_stim: got %h, required 00", stim_o); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_clear: got %b, required 0", done); end
        k = 0;
        wait_done(k);
        n_checks++; if (k !== 33) begin n_fail++; $display("FAIL b2b_latency: got %0d, required 33", k); end
        n_checks++; if (recs.size() !== 64) begin n_fail++; $display("FAIL b2b_count: got %0d, required 64", recs.size()); end
    endtask

    task automatic test_stall_all();
        int k;
        mode = 0; recs.delete();
        rec_ready = 1'b0;
        do_start();
        k = 0;
        repeat (10) begin tick(); k++; end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL stall_busy: got %b, required 1", busy); end
        n_checks++; if (stim_o !== 5'd1) begin n_fail++; $display("FAIL stall_stim: got %h, required 01", stim_o); end
        n_checks++; if (rec_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid: got %b, required 1", rec_valid); end
        n_checks++; if (rec_data !== 10'h00F) begin n_fail++; $display("FAIL stall_data: got %h, required 00f", rec_data); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL stall_done: got %b, required 0", done); end
        rec_ready = 1'b1;
        wait_done(k);
        n_checks++; if (k !== 42) begin n_fail++; $display("FAIL stall_latency: got %0d, required 42", k); end
        n_checks++; if (recs.size() !== 32) begin n_fail++; $display("FAIL stall_count: got %0d, required 32", recs.size()); end
        n_checks++; if (signature !== sig_model(0)) begin n_fail++; $display("FAIL stall_sig: got %h, required %h", signature, sig_model(0)); end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_signatures();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_stall_all();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
